// File: rtl/operand_feeder_if.sv
// operand_feeder_if: host write, bias, control and consumer handshake bundle for operand_feeder.
interface operand_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 4,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic wr_valid, wr_ready, bias_we, go, clear, advance, consumer_done;
  logic start_out, busy, batch_done;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] wr_a, wr_b, bias_in, a_out_array, b_out_array, bias_array;
  logic [CW-1:0] length_out, count;
  modport slave (
    input  wr_valid, wr_a, wr_b, bias_we, bias_in, go, clear, advance, consumer_done,
    output wr_ready, start_out, length_out, a_out_array, b_out_array, bias_array, count, busy, batch_done
  );
  modport master (
    output wr_valid, wr_a, wr_b, bias_we, bias_in, go, clear, advance, consumer_done,
    input  wr_ready, start_out, length_out, a_out_array, b_out_array, bias_array, count, busy, batch_done
  );
endinterface

// File: rtl/operand_feeder.sv
// operand_feeder: buffers operand pairs and a bias vector, then feeds them to the dot-product unit one batch at a time.
// Define OPERAND_FEEDER_REPLAY_EN to keep each batch in the buffer so a later go re-issues it.
module operand_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 4,
  parameter int DEPTH      = 8
) (
  input logic clk,
  input logic reset,
  operand_feeder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] LOAD = 2'd0, ISSUE = 2'd1, RUN = 2'd2, WAIT_DONE = 2'd3;
  typedef logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] vec_t;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, rem_q, rem_d, len_q, len_d;
  vec_t bias_q, bias_d;
  vec_t mem_a_q [DEPTH];
  vec_t mem_b_q [DEPTH];
  logic wr_fire, head;
`ifdef OPERAND_FEEDER_REPLAY_EN
  logic [PW-1:0] base_q, base_d;
`endif
  assign bus.wr_ready    = state_q == LOAD && cnt_q < FULL;
  assign wr_fire         = bus.wr_valid && bus.wr_ready && !bus.clear;
  assign head            = state_q == ISSUE || state_q == RUN;
  assign bus.a_out_array = head ? mem_a_q[rd_q] : '0;
  assign bus.b_out_array = head ? mem_b_q[rd_q] : '0;
  assign bus.start_out   = state_q == ISSUE;
  assign bus.busy        = state_q != LOAD;
  assign bus.batch_done  = state_q == WAIT_DONE && bus.consumer_done;
  assign bus.length_out  = len_q;
  assign bus.count       = cnt_q;
  assign bus.bias_array  = bias_q;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    len_d   = len_q;
    bias_d  = bus.bias_we && state_q == LOAD ? bus.bias_in : bias_q;
`ifdef OPERAND_FEEDER_REPLAY_EN
    base_d  = base_q;
`endif
    case (state_q)
      LOAD: begin
        if (bus.clear) begin
          rd_d  = '0;
          wr_d  = '0;
          cnt_d = '0;
        end else begin
          wr_d  = wr_fire ? wr_q + 1'b1 : wr_q;
          cnt_d = wr_fire ? cnt_q + 1'b1 : cnt_q;
          // length is latched at go so it is already valid alongside the start pulse
          if (bus.go && cnt_d != '0) begin
            state_d = ISSUE;
            len_d   = cnt_d;
            rem_d   = cnt_d;
`ifdef OPERAND_FEEDER_REPLAY_EN
            base_d  = rd_q;
`endif
          end
        end
      end
      ISSUE: state_d = RUN;
      RUN: if (bus.advance) begin
        rd_d    = rd_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == CW'(1) ? WAIT_DONE : RUN;
      end
      WAIT_DONE: if (bus.consumer_done) begin
        state_d = LOAD;
`ifdef OPERAND_FEEDER_REPLAY_EN
        rd_d    = base_q;
        cnt_d   = len_q;
`endif
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      bias_q  <= bias_d;
    end
  end
`ifdef OPERAND_FEEDER_REPLAY_EN
  always_ff @(posedge clk) begin
    if (reset) base_q <= '0;
    else base_q <= base_d;
  end
`endif
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_a_q[wr_q] <= bus.wr_a;
      mem_b_q[wr_q] <= bus.wr_b;
    end
  end
endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: table-driven first batch, then directed corner cases and random traffic against a queue model.
module tb_operand_feeder;
  localparam int DW = 16, NU = 4, DEPTH = 8, W = NU * DW;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  operand_feeder_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .DEPTH(DEPTH)) bus ();
  operand_feeder #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic rs, wv, go, adv, cd, clr, bwe; logic [W-1:0] a, b, bi;} in_t;
  typedef struct {logic [W-1:0] a, b;} pair_t;
  typedef struct {in_t x; logic wrr, st, bsy, bd; logic [3:0] len, cnt; logic [W-1:0] ea, eb, ebi;} vec_t;
  int checks = 0, errors = 0;
  pair_t q[$];
  pair_t saved[$];
  int ph = 0, left = 0;
  logic [3:0] len_m = '0;
  logic [W-1:0] bias_m = '0;
  vec_t tv[11];

  function automatic logic [W-1:0] mk(int v);
    logic [W-1:0] r = '0;
    if (v != 0) for (int l = 0; l < NU; l++) r[l*DW +: DW] = DW'(v + l);
    return r;
  endfunction

  function automatic in_t idle();
    in_t x = '{default: '0};
    return x;
  endfunction

  function automatic vec_t row(logic [4:0] ib, int a, int b, int bi, logic [3:0] eo, int len, int cnt, int oa, int ob, int obi);
    vec_t v;
    v.x = idle();
    {v.x.wv, v.x.go, v.x.adv, v.x.cd, v.x.bwe} = ib;
    v.x.a = mk(a); v.x.b = mk(b); v.x.bi = mk(bi);
    {v.wrr, v.st, v.bsy, v.bd} = eo;
    v.len = 4'(len); v.cnt = 4'(cnt);
    v.ea = mk(oa); v.eb = mk(ob); v.ebi = mk(obi);
    return v;
  endfunction

  task automatic drive(input in_t x);
    reset = x.rs;
    bus.wr_valid = x.wv; bus.go = x.go; bus.advance = x.adv; bus.consumer_done = x.cd;
    bus.clear = x.clr; bus.bias_we = x.bwe;
    bus.wr_a = x.a; bus.wr_b = x.b; bus.bias_in = x.bi;
  endtask

  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", n, $time, got, exp);
    end
  endtask

  task automatic cmp_all(input logic wrr, st, bsy, bd, input logic [3:0] len, cnt, input logic [W-1:0] ea, eb, ebi);
    chk("wr_ready", W'(bus.wr_ready), W'(wrr));
    chk("start_out", W'(bus.start_out), W'(st));
    chk("busy", W'(bus.busy), W'(bsy));
    chk("batch_done", W'(bus.batch_done), W'(bd));
    chk("length_out", W'(bus.length_out), W'(len));
    chk("count", W'(bus.count), W'(cnt));
    chk("a_out", bus.a_out_array, ea);
    chk("b_out", bus.b_out_array, eb);
    chk("bias", bus.bias_array, ebi);
  endtask

  // Reference model: the buffer is a queue, the issued batch a saved copy of it.
  task automatic model_step(input in_t x);
    if (x.rs) begin
      q.delete(); saved.delete(); ph = 0; left = 0; len_m = '0; bias_m = '0;
    end else case (ph)
      0: begin
        if (x.bwe) bias_m = x.bi;
        if (x.clr) q.delete();
        else begin
          if (x.wv && q.size() < DEPTH) q.push_back('{x.a, x.b});
          if (x.go && q.size() > 0) begin ph = 1; len_m = 4'(q.size()); saved = q; end
        end
      end
      1: begin ph = 2; left = int'(len_m); end
      2: if (x.adv) begin void'(q.pop_front()); left--; if (left == 0) ph = 3; end
      default: if (x.cd) begin
        ph = 0;
`ifdef OPERAND_FEEDER_REPLAY_EN
        q = saved;
`endif
      end
    endcase
  endtask

  task automatic tick(input in_t x);
    logic hd;
    drive(x);
    #1;
    hd = ph == 1 || ph == 2;
    cmp_all(ph == 0 && q.size() < DEPTH, ph == 1, ph != 0, ph == 3 && x.cd, len_m, 4'(q.size()),
            hd ? q[0].a : '0, hd ? q[0].b : '0, bias_m);
    @(posedge clk);
    model_step(x);
    #1;
  endtask

  task automatic wr(input int a, input int b);
    in_t x = idle();
    x.wv = 1'b1; x.a = mk(a); x.b = mk(b);
    tick(x);
  endtask

  task automatic ctl(input logic go, adv, cd, clr, rs);
    in_t x = idle();
    x.go = go; x.adv = adv; x.cd = cd; x.clr = clr; x.rs = rs;
    tick(x);
  endtask

  task automatic finish_batch();
    for (int k = 0; k < 40 && ph != 3; k++) ctl(0, 1, 0, 0, 0);
    ctl(0, 0, 1, 0, 0);
  endtask

  initial begin
    in_t x;
    int rc;
`ifdef OPERAND_FEEDER_REPLAY_EN
    rc = 3;
`else
    rc = 0;
`endif
    tv[0]  = row(5'b10001, 1, 10, 5, 4'b1000, 0, 0, 0, 0, 0);
    tv[1]  = row(5'b10000, 2, 20, 0, 4'b1000, 0, 1, 0, 0, 5);
    tv[2]  = row(5'b10000, 3, 30, 0, 4'b1000, 0, 2, 0, 0, 5);
    tv[3]  = row(5'b01000, 0, 0, 0, 4'b1000, 0, 3, 0, 0, 5);
    tv[4]  = row(5'b00000, 0, 0, 0, 4'b0110, 3, 3, 1, 10, 5);
    tv[5]  = row(5'b00110, 0, 0, 0, 4'b0010, 3, 3, 1, 10, 5);
    tv[6]  = row(5'b00100, 0, 0, 0, 4'b0010, 3, 2, 2, 20, 5);
    tv[7]  = row(5'b00100, 0, 0, 0, 4'b0010, 3, 1, 3, 30, 5);
    tv[8]  = row(5'b00100, 0, 0, 0, 4'b0010, 3, 0, 0, 0, 5);
    tv[9]  = row(5'b00010, 0, 0, 0, 4'b0011, 3, 0, 0, 0, 5);
    tv[10] = row(5'b00000, 0, 0, 0, 4'b1000, 3, rc, 0, 0, 5);
    x = idle(); x.rs = 1'b1;
    drive(x);
    repeat (2) @(posedge clk);
    #1;
    drive(idle());
    #1;
    cmp_all(1, 0, 0, 0, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    for (int k = 0; k < 11; k++) begin
      drive(tv[k].x);
      #1;
      cmp_all(tv[k].wrr, tv[k].st, tv[k].bsy, tv[k].bd, tv[k].len, tv[k].cnt, tv[k].ea, tv[k].eb, tv[k].ebi);
      @(posedge clk); #1;
    end
    x = idle(); x.rs = 1'b1;
    drive(x);
    @(posedge clk);
    model_step(x);
    #1;
    // fill to DEPTH, ninth write must be dropped, then drain everything
    for (int i = 0; i < 9; i++) wr(100 + i, 200 + i);
    chk("full_wr_ready", W'(bus.wr_ready), W'(1'b0));
    ctl(1, 0, 0, 0, 0);
    finish_batch();
    // pointer wrap-around
    ctl(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) wr(300 + i, 400 + i);
    ctl(1, 0, 0, 0, 0);
    finish_batch();
    for (int i = 0; i < 6; i++) wr(500 + i, 600 + i);
    ctl(1, 0, 0, 0, 0);
    finish_batch();
    // empty go is ignored; go with a same-cycle write issues length 1
    ctl(0, 0, 0, 1, 0);
    ctl(1, 0, 0, 0, 0);
    ctl(0, 0, 0, 0, 0);
    x = idle(); x.wv = 1'b1; x.go = 1'b1; x.a = mk(700); x.b = mk(800);
    tick(x);
    chk("go_write_len", W'(bus.length_out), W'(4'd1));
    finish_batch();
    // reset in the middle of a batch
    ctl(0, 0, 0, 1, 0);
    wr(11, 12); wr(13, 14);
    ctl(1, 0, 0, 0, 0);
    ctl(0, 0, 0, 0, 0);
    ctl(0, 1, 0, 0, 0);
    ctl(0, 0, 0, 0, 1);
    chk("rst_busy", W'(bus.busy), W'(1'b0));
    wr(15, 16);
    ctl(0, 0, 0, 1, 0);
`ifdef OPERAND_FEEDER_REPLAY_EN
    wr(21, 22); wr(23, 24);
    ctl(1, 0, 0, 0, 0);
    finish_batch();
    chk("replay_count", W'(bus.count), W'(4'd2));
    ctl(1, 0, 0, 0, 0);
    chk("replay_a", bus.a_out_array, mk(21));
    finish_batch();
    ctl(0, 0, 0, 1, 0);
    ctl(1, 0, 0, 0, 0);
    chk("clear_go_start", W'(bus.start_out), W'(1'b0));
`endif
    for (int n = 0; n < 3000; n++) begin
      x = idle();
      x.rs  = $urandom_range(0, 199) == 0;
      x.wv  = $urandom_range(0, 1) == 1;
      x.go  = $urandom_range(0, 9) == 0;
      x.adv = $urandom_range(0, 1) == 1;
      x.cd  = $urandom_range(0, 3) == 0;
      x.clr = $urandom_range(0, 39) == 0;
      x.bwe = $urandom_range(0, 9) == 0;
      x.a   = {$urandom, $urandom};
      x.b   = {$urandom, $urandom};
      x.bi  = {$urandom, $urandom};
      tick(x);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
